// File: rtl/cache_types_pkg.sv
// rtl/cache_types_pkg.sv - shared types and widths for the cache line burst adapter
package cache_types_pkg;

  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } burst_state_t;

endpackage

// File: rtl/cacheline_burst_adapter.sv
// rtl/cacheline_burst_adapter.sv - turns 256-bit cache line requests into 4-beat 64-bit memory bursts
module cacheline_burst_adapter
  import cache_types_pkg::*;
#(
  parameter int S_LINE = LINE_W,
  parameter int S_BEAT = BEAT_W,
  parameter int S_ADDR = ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [S_ADDR-1:0] pmem_address,
  input  logic [S_LINE-1:0] pmem_wdata,
  output logic [S_LINE-1:0] pmem_rdata,
  output logic              mem_resp,
  output logic              burst_read,
  output logic              burst_write,
  output logic [S_ADDR-1:0] burst_address,
  output logic [S_BEAT-1:0] burst_wdata,
  input  logic [S_BEAT-1:0] burst_rdata,
  input  logic              burst_resp
);

  localparam int N_BEATS  = S_LINE / S_BEAT;
  localparam int S_OFFSET = $clog2(S_LINE / 8);
  localparam int CNT_W    = $clog2(N_BEATS);

  burst_state_t       state;
  burst_state_t       next_state;
  logic [CNT_W-1:0]   beat;
  logic               last_beat;
  logic               addr_lsb_unused;

  assign addr_lsb_unused = ^pmem_address[S_OFFSET-1:0];
  assign last_beat       = burst_resp && (beat == CNT_W'(N_BEATS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (pmem_write)     next_state = WR_BURST;
        else if (pmem_read) next_state = RD_BURST;
      end
      RD_BURST: if (last_beat) next_state = DONE;
      WR_BURST: if (last_beat) next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    burst_read  = 1'b0;
    burst_write = 1'b0;
    mem_resp    = 1'b0;
    burst_wdata = '0;
    unique case (state)
      RD_BURST: burst_read = 1'b1;
      WR_BURST: begin
        burst_write = 1'b1;
        burst_wdata = pmem_wdata[S_BEAT*int'(beat) +: S_BEAT];
      end
      DONE:     mem_resp = 1'b1;
      default:  ;
    endcase
  end

  // The beat counter wraps to zero on the last beat, so it is ready for the next burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat          <= '0;
      burst_address <= '0;
      pmem_rdata    <= '0;
    end else begin
      if (state == IDLE && (pmem_read || pmem_write))
        burst_address <= {pmem_address[S_ADDR-1:S_OFFSET], {S_OFFSET{1'b0}}};
      if ((state == RD_BURST || state == WR_BURST) && burst_resp)
        beat <= beat + CNT_W'(1);
      if (state == RD_BURST && burst_resp)
        pmem_rdata[S_BEAT*int'(beat) +: S_BEAT] <= burst_rdata;
    end
  end

endmodule
